// File: rtl/fifo_unpack.sv
`default_nettype none
// ============================================================================
// Module   : fifo_unpack
// Purpose  : Splits IN_WIDTH FIFO words into RATIO narrow valid/ready beats.
//            Optional zero-latency first beat: FIFO_UNPACK_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module fifo_unpack #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_fifo_empty,
    input  logic [IN_WIDTH-1:0]                   i_fifo_rdata,
    output logic                                  o_fifo_pop,
    input  logic                                  i_flush,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic [OUT_WIDTH-1:0]                  o_data,
    output logic                                  o_last,
    output logic [$clog2(IN_WIDTH/OUT_WIDTH)-1:0] o_beat_idx
);

    localparam int               RATIO    = IN_WIDTH / OUT_WIDTH;
    localparam int               CNT_W    = $clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [IN_WIDTH-1:0]  hold_word;
    logic                 load;
    logic [CNT_W-1:0]     slice_sel;
    logic [OUT_WIDTH-1:0] hold_beat;

    // Beat order only changes which slice the counter selects.
    assign slice_sel = LSB_FIRST ? cnt : (LAST_IDX - cnt);

    always_comb begin
        hold_beat = hold_word[OUT_WIDTH-1:0];
        for (int i = 0; i < RATIO; i++) begin
            if (slice_sel == CNT_W'(i)) begin
                hold_beat = hold_word[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

`ifdef FIFO_UNPACK_BYPASS_EN
    logic [OUT_WIDTH-1:0] head_beat;

    assign head_beat = LSB_FIRST ? i_fifo_rdata[OUT_WIDTH-1:0]
                                 : i_fifo_rdata[IN_WIDTH-1 -: OUT_WIDTH];
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        load       = 1'b0;
        o_fifo_pop = 1'b0;
        o_valid    = 1'b0;
        o_data     = hold_beat;
        o_last     = 1'b0;
        o_beat_idx = '0;
        // Reset and flush both suppress any transfer in the current cycle.
        if (!i_rst_n || i_flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!i_fifo_empty) begin
`ifdef FIFO_UNPACK_BYPASS_EN
                        o_valid = 1'b1;
                        o_data  = head_beat;
                        if (i_ready) begin
                            o_fifo_pop = 1'b1;
                            load       = 1'b1;
                            cnt_nxt    = CNT_W'(1);
                            state_nxt  = HOLD;
                        end
`else
                        o_fifo_pop = 1'b1;
                        load       = 1'b1;
                        cnt_nxt    = '0;
                        state_nxt  = HOLD;
`endif
                    end
                end
                HOLD: begin
                    o_valid    = 1'b1;
                    o_beat_idx = cnt;
                    o_last     = (cnt == LAST_IDX);
                    if (i_ready) begin
                        if (cnt != LAST_IDX) begin
                            cnt_nxt = cnt + 1'b1;
                        end else if (!i_fifo_empty) begin
                            o_fifo_pop = 1'b1;
                            load       = 1'b1;
                            cnt_nxt    = '0;
                        end else begin
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The holding register carries data only; it needs no reset.
    always_ff @(posedge i_clk) begin
        if (load) begin
            hold_word <= i_fifo_rdata;
        end
    end

`ifdef SIMULATION
    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_params
        $error("fifo_unpack: IN_WIDTH must be a multiple of OUT_WIDTH with RATIO >= 2");
    end

    a_no_pop_when_empty : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_fifo_pop && i_fifo_empty));

    a_data_stable : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_valid && !i_ready) |=> (!o_valid || $stable(o_data)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_unpack.sv
`default_nettype none
// Bench for fifo_unpack: FIFO model plus beat scoreboard on the LSB-first
// instance, and an MSB-first instance checked inline.
module tb_fifo_unpack;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        flush   = 1'b0;
    logic        ready   = 1'b0;
    logic        empty_a = 1'b1;
    logic        empty_b = 1'b1;
    logic [31:0] rdata_a = '0;
    logic [31:0] rdata_b = '0;

    logic        pop_a, valid_a, last_a;
    logic [7:0]  data_a;
    logic [1:0]  idx_a;
    logic        pop_b, valid_b, last_b;
    logic [7:0]  data_b;
    logic [1:0]  idx_b;

    int          compared   = 0;
    int          mismatched = 0;

    logic [31:0] fq_a[$];
    logic [31:0] fq_b[$];
    logic [7:0]  exp_a[$];
    logic        pop_a_s = 1'b0;
    logic        pop_b_s = 1'b0;

    always #5 clk = ~clk;

    fifo_unpack #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .i_clk(clk), .i_rst_n(rst_n), .i_fifo_empty(empty_a), .i_fifo_rdata(rdata_a),
        .o_fifo_pop(pop_a), .i_flush(flush), .o_valid(valid_a), .i_ready(ready),
        .o_data(data_a), .o_last(last_a), .o_beat_idx(idx_a)
    );

    fifo_unpack #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .i_clk(clk), .i_rst_n(rst_n), .i_fifo_empty(empty_b), .i_fifo_rdata(rdata_b),
        .o_fifo_pop(pop_b), .i_flush(flush), .o_valid(valid_b), .i_ready(ready),
        .o_data(data_b), .o_last(last_b), .o_beat_idx(idx_b)
    );

    // FIFO model: apply the pop seen this cycle, then refresh head/empty.
    always @(posedge clk) begin
        #1;
        if (pop_a_s && fq_a.size() > 0) void'(fq_a.pop_front());
        if (pop_b_s && fq_b.size() > 0) void'(fq_b.pop_front());
        #1;
        empty_a = (fq_a.size() == 0);
        rdata_a = (fq_a.size() == 0) ? 32'h0 : fq_a[0];
        empty_b = (fq_b.size() == 0);
        rdata_b = (fq_b.size() == 0) ? 32'h0 : fq_b[0];
    end

    // Monitor: pop legality every cycle, scoreboard on every handshake.
    always @(negedge clk) begin
        logic [7:0] e;
        pop_a_s = pop_a;
        pop_b_s = pop_b;
        compared++;
        if ((pop_a && empty_a) || (pop_b && empty_b)) begin
            mismatched++;
            $display("FAIL pop_while_empty: pop_a=%b empty_a=%b pop_b=%b empty_b=%b, expected no pop on empty",
                     pop_a, empty_a, pop_b, empty_b);
        end
        if (valid_a && ready) begin
            compared++;
            if (exp_a.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_beat: got data=%h, expected no beat", data_a);
            end else begin
                e = exp_a.pop_front();
                if (data_a !== e) begin
                    mismatched++;
                    $display("FAIL scoreboard_data: got %h, expected %h", data_a, e);
                end
            end
        end
    end

    task automatic push_a(input logic [31:0] w);
        fq_a.push_back(w);
        for (int k = 0; k < 4; k++) exp_a.push_back(8'(w >> (8*k)));
    endtask

    task automatic wait_idle();
        bit done = 0;
        ready = 1'b1;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            if (!valid_a && !pop_a && fq_a.size() == 0 && exp_a.size() == 0) done = 1;
        end
        compared++;
        if (!done) begin
            mismatched++;
            $display("FAIL drain_timeout: valid=%b pending=%0d, expected idle", valid_a, exp_a.size());
        end
    endtask

    // Advance until lsb instance shows beat index `want`; returns 0 on timeout.
    task automatic wait_beat(input logic [1:0] want, output bit found);
        found = 0;
        for (int n = 0; n < 12 && !found; n++) begin
            @(posedge clk); #1;
            if (valid_a && idx_a == want) found = 1;
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL wait_beat_timeout: idx=%0d, expected idx %0d to appear", idx_a, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if (valid_a !== 1'b0 || pop_a !== 1'b0 || last_a !== 1'b0 || idx_a !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_lsb: valid=%b pop=%b last=%b idx=%0d, expected all 0",
                     valid_a, pop_a, last_a, idx_a);
        end
        compared++;
        if (valid_b !== 1'b0 || pop_b !== 1'b0 || last_b !== 1'b0 || idx_b !== 2'd0) begin
            mismatched++;
            $display("FAIL reset_msb: valid=%b pop=%b last=%b idx=%0d, expected all 0",
                     valid_b, pop_b, last_b, idx_b);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (valid_a !== 1'b0 || pop_a !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_empty: valid=%b pop=%b, expected 0 0", valid_a, pop_a);
        end
    endtask

    task automatic test_basic();
        logic [31:0] w;
        logic        exp_pop;
        w = 32'hDDCCBBAA;
        ready = 1'b1;
        @(posedge clk); #1;
        push_a(w);
`ifndef FIFO_UNPACK_BYPASS_EN
        @(negedge clk);
        compared++;
        if (pop_a !== 1'b1 || valid_a !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_load: pop=%b valid=%b, expected pop=1 valid=0", pop_a, valid_a);
        end
        @(posedge clk);
`endif
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
`ifdef FIFO_UNPACK_BYPASS_EN
            exp_pop = (k == 0);
`else
            exp_pop = 1'b0;
`endif
            compared++;
            if (valid_a !== 1'b1 || data_a !== 8'(w >> (8*k)) || idx_a !== 2'(k) ||
                last_a !== (k == 3) || pop_a !== exp_pop) begin
                mismatched++;
                $display("FAIL basic_beat%0d: valid=%b data=%h idx=%0d last=%b pop=%b, expected 1 %h %0d %b %b",
                         k, valid_a, data_a, idx_a, last_a, pop_a, 8'(w >> (8*k)), k, (k == 3), exp_pop);
            end
            @(posedge clk);
        end
        @(negedge clk);
        compared++;
        if (valid_a !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_idle_after: valid=%b, expected 0", valid_a);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w0, w1, w;
        logic        exp_pop;
        w0 = 32'h44332211;
        w1 = 32'h88776655;
        ready = 1'b1;
        @(posedge clk); #1;
        push_a(w0);
        push_a(w1);
`ifndef FIFO_UNPACK_BYPASS_EN
        @(negedge clk);
        compared++;
        if (pop_a !== 1'b1 || valid_a !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_load: pop=%b valid=%b, expected pop=1 valid=0", pop_a, valid_a);
        end
        @(posedge clk);
`endif
        for (int k = 0; k < 8; k++) begin
            w = (k < 4) ? w0 : w1;
            @(negedge clk);
`ifdef FIFO_UNPACK_BYPASS_EN
            exp_pop = (k == 0) || (k == 3);
`else
            exp_pop = (k == 3);
`endif
            compared++;
            if (valid_a !== 1'b1 || data_a !== 8'(w >> (8*(k % 4))) || idx_a !== 2'(k % 4) ||
                pop_a !== exp_pop) begin
                mismatched++;
                $display("FAIL b2b_beat%0d: valid=%b data=%h idx=%0d pop=%b, expected 1 %h %0d %b",
                         k, valid_a, data_a, idx_a, pop_a, 8'(w >> (8*(k % 4))), k % 4, exp_pop);
            end
            @(posedge clk);
        end
        @(negedge clk);
        compared++;
        if (valid_a !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_idle_after: valid=%b, expected 0", valid_a);
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        bit found;
        ready = 1'b1;
        @(posedge clk); #1;
        push_a(32'hDDCCBBAA);
        wait_beat(2'd1, found);
        if (found) begin
            ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                compared++;
                if (valid_a !== 1'b1 || data_a !== 8'hBB || idx_a !== 2'd1 || pop_a !== 1'b0) begin
                    mismatched++;
                    $display("FAIL stall_cycle%0d: valid=%b data=%h idx=%0d pop=%b, expected 1 bb 1 0",
                             i, valid_a, data_a, idx_a, pop_a);
                end
                @(posedge clk); #1;
            end
            ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            compared++;
            if (valid_a !== 1'b1 || data_a !== 8'hCC || idx_a !== 2'd2) begin
                mismatched++;
                $display("FAIL stall_resume: valid=%b data=%h idx=%0d, expected 1 cc 2",
                         valid_a, data_a, idx_a);
            end
        end
        wait_idle();
    endtask

    task automatic test_flush();
        bit found;
        bit seen = 0;
        ready = 1'b1;
        @(posedge clk); #1;
        push_a(32'hDDCCBBAA);
        push_a(32'h88776655);
        wait_beat(2'd2, found);
        if (found) begin
            flush = 1'b1;
            void'(exp_a.pop_front());
            void'(exp_a.pop_front());
            @(negedge clk);
            compared++;
            if (valid_a !== 1'b0 || pop_a !== 1'b0) begin
                mismatched++;
                $display("FAIL flush_cycle: valid=%b pop=%b, expected 0 0", valid_a, pop_a);
            end
            @(posedge clk); #1;
            flush = 1'b0;
            for (int n = 0; n < 4 && !seen; n++) begin
                @(negedge clk);
                if (valid_a) begin
                    seen = 1;
                    compared++;
                    if (data_a !== 8'h55 || idx_a !== 2'd0) begin
                        mismatched++;
                        $display("FAIL flush_next: data=%h idx=%0d, expected 55 0", data_a, idx_a);
                    end
                end
                @(posedge clk);
            end
            compared++;
            if (!seen) begin
                mismatched++;
                $display("FAIL flush_timeout: valid=%b, expected beat 55", valid_a);
            end
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        bit found;
        ready = 1'b1;
        @(posedge clk); #1;
        push_a(32'hDDCCBBAA);
        wait_beat(2'd2, found);
        if (found) begin
            rst_n = 1'b0;
            fq_a.delete();
            exp_a.delete();
            @(negedge clk);
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            compared++;
            if (valid_a !== 1'b0 || idx_a !== 2'd0 || pop_a !== 1'b0 || last_a !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_mid: valid=%b idx=%0d pop=%b last=%b, expected all 0",
                         valid_a, idx_a, pop_a, last_a);
            end
        end
        wait_idle();
    endtask

    task automatic test_msb_first();
        logic [31:0] w;
        w = 32'hDDCCBBAA;
        ready = 1'b1;
        @(posedge clk); #1;
        fq_b.push_back(w);
`ifndef FIFO_UNPACK_BYPASS_EN
        @(negedge clk);
        compared++;
        if (pop_b !== 1'b1 || valid_b !== 1'b0) begin
            mismatched++;
            $display("FAIL msb_load: pop=%b valid=%b, expected pop=1 valid=0", pop_b, valid_b);
        end
        @(posedge clk);
`endif
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            compared++;
            if (valid_b !== 1'b1 || data_b !== 8'(w >> (8*(3-k))) || idx_b !== 2'(k) ||
                last_b !== (k == 3)) begin
                mismatched++;
                $display("FAIL msb_beat%0d: valid=%b data=%h idx=%0d last=%b, expected 1 %h %0d %b",
                         k, valid_b, data_b, idx_b, last_b, 8'(w >> (8*(3-k))), k, (k == 3));
            end
            @(posedge clk);
        end
        @(negedge clk);
        compared++;
        if (valid_b !== 1'b0 || fq_b.size() != 0) begin
            mismatched++;
            $display("FAIL msb_idle_after: valid=%b fifo_words=%0d, expected 0 0", valid_b, fq_b.size());
        end
    endtask

`ifdef FIFO_UNPACK_BYPASS_EN
    task automatic test_bypass_stall();
        ready = 1'b0;
        @(posedge clk); #1;
        push_a(32'hDDCCBBAA);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            compared++;
            if (valid_a !== 1'b1 || data_a !== 8'hAA || pop_a !== 1'b0 || idx_a !== 2'd0 || last_a !== 1'b0) begin
                mismatched++;
                $display("FAIL bypass_hold%0d: valid=%b data=%h pop=%b idx=%0d last=%b, expected 1 aa 0 0 0",
                         i, valid_a, data_a, pop_a, idx_a, last_a);
            end
            @(posedge clk); #1;
        end
        ready = 1'b1;
        @(negedge clk);
        compared++;
        if (valid_a !== 1'b1 || data_a !== 8'hAA || pop_a !== 1'b1) begin
            mismatched++;
            $display("FAIL bypass_release: valid=%b data=%h pop=%b, expected 1 aa 1", valid_a, data_a, pop_a);
        end
        @(posedge clk);
        @(negedge clk);
        compared++;
        if (data_a !== 8'hBB || idx_a !== 2'd1) begin
            mismatched++;
            $display("FAIL bypass_second: data=%h idx=%0d, expected bb 1", data_a, idx_a);
        end
        wait_idle();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_msb_first();
`ifdef FIFO_UNPACK_BYPASS_EN
        test_bypass_stall();
`endif
        compared++;
        if (exp_a.size() != 0) begin
            mismatched++;
            $display("FAIL leftover_beats: %0d pending, expected 0", exp_a.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
